carwash_sequencer: RTL

- Timed, parametrised successor to the button-stepped car-wash display controller.
- The user selects a wash program on SW7/SW6/SW5 and presses BTN3 to start. The block then advances through the program's wash steps automatically, one step every STEP_CYCLES clocks.
- It drives the two-digit 7-segment pair (seg2 = left digit, seg = right digit) and exposes step, busy and done status to the top level.
- BTN0 aborts a wash at any time.

---
 rtl/carwash_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/carwash_sequencer.sv
// Timed car-wash sequencer: latches a wash program on a start edge and steps
// through its two-digit glyph pairs, one step every STEP_CYCLES clocks.
module carwash_sequencer #(
   parameter int STEP_CYCLES = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       BTN3,
   input  logic       BTN0,
   input  logic       SW7,
   input  logic       SW6,
   input  logic       SW5,
   output logic [6:0] seg,
   output logic [6:0] seg2,
   output logic [3:0] step_idx,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {P_NONE, P_BASIC, P_ECON, P_PREM} prog_t;

   localparam logic [6:0] G_B     = 7'b0011111;
   localparam logic [6:0] G_P     = 7'b1100111;
   localparam logic [6:0] G_S     = 7'b1011011;
   localparam logic [6:0] G_F     = 7'b1000111;
   localparam logic [6:0] G_C     = 7'b1001110;
   localparam logic [6:0] G_I     = 7'b0000110;
   localparam logic [6:0] G_R     = 7'b1000110;
   localparam logic [6:0] G_9     = 7'b1110011;
   localparam logic [6:0] G_E     = 7'b1001111;
   localparam logic [6:0] G_U     = 7'b0111110;
   localparam logic [6:0] G_D     = 7'b0111101;
   localparam logic [6:0] G_H     = 7'b0110111;
   localparam logic [6:0] G_BLANK = 7'b0000000;
   localparam logic [6:0] G_DASH  = 7'b0000001;

   localparam logic [CNT_W-1:0] TC = CNT_W'(STEP_CYCLES - 1);

   // Returns {left, right} glyphs for a program step.
   function automatic logic [13:0] glyphs(input prog_t p, input logic [3:0] i);
      logic [13:0] g;
      g = {G_DASH, G_DASH};
      case (p)
         P_BASIC: begin
            case (i)
               4'd0:    g = {G_B, G_P};
               4'd1:    g = {G_S, G_F};
               4'd2:    g = {G_C, G_BLANK};
               4'd3:    g = {G_R, G_I};
               4'd4:    g = {G_9, G_BLANK};
               default: g = {G_DASH, G_DASH};
            endcase
         end
         P_ECON: begin
            case (i)
               4'd0:    g = {G_E, G_P};
               4'd1:    g = {G_P, G_S};
               4'd2:    g = {G_C, G_BLANK};
               4'd3:    g = {G_S, G_F};
               4'd4:    g = {G_C, G_BLANK};
               4'd5:    g = {G_R, G_I};
               4'd6:    g = {G_9, G_BLANK};
               default: g = {G_DASH, G_DASH};
            endcase
         end
         P_PREM: begin
            case (i)
               4'd0:    g = {G_P, G_P};
               4'd1:    g = {G_P, G_S};
               4'd2:    g = {G_C, G_BLANK};
               4'd3:    g = {G_S, G_F};
               4'd4:    g = {G_C, G_BLANK};
               4'd5:    g = {G_R, G_I};
               4'd6:    g = {G_U, G_U};
               4'd7:    g = {G_C, G_BLANK};
               4'd8:    g = {G_R, G_I};
               4'd9:    g = {G_D, G_BLANK};
               4'd10:   g = {G_R, G_S};
               4'd11:   g = {G_S, G_H};
               4'd12:   g = {G_9, G_BLANK};
               default: g = {G_DASH, G_DASH};
            endcase
         end
         default: g = {G_DASH, G_DASH};
      endcase
      return g;
   endfunction

   function automatic logic [3:0] last_step(input prog_t p);
      logic [3:0] l;
      case (p)
         P_BASIC: l = 4'd4;
         P_ECON:  l = 4'd6;
         P_PREM:  l = 4'd12;
         default: l = 4'd0;
      endcase
      return l;
   endfunction

   // Bit order: BTN3, BTN0, SW7, SW6, SW5
   logic [4:0] raw;
   logic [4:0] sync1_reg;
   logic [4:0] sync2_reg;
   logic       btn3_prev_reg;

   assign raw = {BTN3, BTN0, SW7, SW6, SW5};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg     <= '0;
         sync2_reg     <= '0;
         btn3_prev_reg <= 1'b0;
      end else begin
         sync1_reg     <= raw;
         sync2_reg     <= sync1_reg;
         btn3_prev_reg <= sync2_reg[4];
      end
   end

   logic  start;
   logic  abort;
   prog_t sel;

   assign start = sync2_reg[4] & ~btn3_prev_reg;
   assign abort = sync2_reg[3];

   always_comb begin
      sel = P_NONE;
      if (sync2_reg[2])
         sel = P_BASIC;
      else if (sync2_reg[1])
         sel = P_ECON;
      else if (sync2_reg[0])
         sel = P_PREM;
   end

   state_t           state_reg;
   prog_t            prog_reg;
   logic [CNT_W-1:0] timer_reg;
   logic [3:0]       step_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [6:0]       seg_reg;
   logic [6:0]       seg2_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         prog_reg  <= P_NONE;
         timer_reg <= '0;
         step_reg  <= 4'd0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         seg_reg   <= G_DASH;
         seg2_reg  <= G_DASH;
      end else begin
         done_reg <= 1'b0;
         if (abort) begin
            // Abort beats start and terminal count, so no done pulse here.
            state_reg <= S_IDLE;
            timer_reg <= '0;
            step_reg  <= 4'd0;
            busy_reg  <= 1'b0;
            seg_reg   <= G_DASH;
            seg2_reg  <= G_DASH;
         end else begin
            case (state_reg)
               S_IDLE, S_DONE: begin
                  if (start && sel != P_NONE) begin
                     state_reg             <= S_RUN;
                     prog_reg              <= sel;
                     timer_reg             <= '0;
                     step_reg              <= 4'd0;
                     busy_reg              <= 1'b1;
                     {seg2_reg, seg_reg}   <= glyphs(sel, 4'd0);
                  end
               end
               S_RUN: begin
                  if (timer_reg == TC) begin
                     timer_reg <= '0;
                     if (step_reg == last_step(prog_reg)) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        step_reg  <= 4'd0;
                        seg_reg   <= G_DASH;
                        seg2_reg  <= G_DASH;
                     end else begin
                        step_reg            <= step_reg + 4'd1;
                        {seg2_reg, seg_reg} <= glyphs(prog_reg, step_reg + 4'd1);
                     end
                  end else begin
                     timer_reg <= timer_reg + CNT_W'(1);
                  end
               end
               default: begin
                  state_reg <= S_IDLE;
                  seg_reg   <= G_DASH;
                  seg2_reg  <= G_DASH;
               end
            endcase
         end
      end
   end

   assign seg      = seg_reg;
   assign seg2     = seg2_reg;
   assign step_idx = step_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;

endmodule
